memory_stage: RTL



---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/llsc_link_reg.sv | 40 ++++
 rtl/memory_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the five-stage MIPS core.
//   word_t     : 32-bit datapath word
//   regbits_t  : 5-bit register index
//   pcsrc_t    : redirect select (none / branch / jump / JR)
//   wsel_t     : writeback data select (ALU / load / link)
//   memstate_t : MEM-stage data-cache handshake state
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10,
        PC_JR  = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wsel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memstate_t;

endpackage

// File: rtl/llsc_link_reg.sv
// llsc_link_reg: load-linked reservation (valid flag + linked address).
// Only instantiated when MEM_LLSC_EN is defined.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   ll_done   : a load-linked access completes this cycle
//   st_done   : any store (including a successful SC) completes this cycle
//   addr      : address of the current access
//   sc_ok     : reservation valid and matches addr
module llsc_link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  ll_done,
    input  logic  st_done,
    input  word_t addr,
    output logic  sc_ok
);

    logic  link_valid_r;
    word_t link_addr_r;

    // Reservation register: set by a completed LL, cleared by a completed store to the linked address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid_r <= 1'b0;
            link_addr_r  <= 32'd0;
        end else if (ll_done) begin
            link_valid_r <= 1'b1;
            link_addr_r  <= addr;
        end else if (st_done && (addr == link_addr_r)) begin
            link_valid_r <= 1'b0;
        end else begin
            link_valid_r <= link_valid_r;
        end
    end

    assign sc_ok = link_valid_r & (link_addr_r == addr);

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the five-stage MIPS pipeline.
// Issues the data-cache request (hit/wait handshake), stalls upstream until
// the access completes, resolves branch/jump/JR redirects and owns the
// MEM/WB pipeline register.
// Optional feature: define MEM_LLSC_EN to enable LL/SC reservation tracking
// (llsc_link_reg). Without it LL acts as LW and SC as SW returning 1.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   *_MEM inputs             : EX/MEM latch contents
//   dhit, dmemload           : cache completion and load data
//   wb_flush                 : squash MEM/WB contents
//   dmemREN/WEN/addr/store   : cache request (combinational)
//   mem_stall                : freeze IF through EX/MEM
//   pc_redirect, pc_target   : redirect request and target
//   valid_WB/RegWr_WB/wreg_WB/wdat_WB : MEM/WB register
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     valid_MEM,
    input  logic     RegWr_MEM,
    input  logic     memtoReg_MEM,
    input  logic     memWr_MEM,
    input  logic     ll_MEM,
    input  logic     sc_MEM,
    input  logic [1:0] PC_Src_MEM,
    input  logic     bne_MEM,
    input  logic     zero_MEM,
    input  logic [1:0] Wsel_MEM,
    input  regbits_t wreg_MEM,
    input  word_t    Output_Port_MEM,
    input  word_t    busA_MEM,
    input  word_t    busB_MEM,
    input  word_t    npc_MEM,
    input  word_t    jump_addr_MEM,
    input  word_t    branch_addr_MEM,
    input  logic     dhit,
    input  word_t    dmemload,
    input  logic     wb_flush,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    output logic     mem_stall,
    output logic     pc_redirect,
    output word_t    pc_target,
    output logic     valid_WB,
    output logic     RegWr_WB,
    output regbits_t wreg_WB,
    output word_t    wdat_WB
);

    memstate_t state_r, state_nxt_s;
    logic      memop_s, memop_eff_s, sc_fail_s;
    logic      req_rd_s, req_wr_s;
    logic      taken_s;
    word_t     target_s, wdat_nxt_s, sc_wdat_s;

    // A write wins when both load and store flags are set.
    assign memop_s     = valid_MEM & (memtoReg_MEM | memWr_MEM);
    assign memop_eff_s = memop_s & ~sc_fail_s;

`ifdef MEM_LLSC_EN
    logic sc_ok_s;

    // A failing SC suppresses its write and never stalls.
    assign sc_fail_s = valid_MEM & sc_MEM & memWr_MEM & ~sc_ok_s;
    assign sc_wdat_s = {31'd0, sc_ok_s};

    llsc_link_reg u_link (
        .CLK     (CLK),
        .RST     (RST),
        .ll_done (req_rd_s & dhit & ll_MEM),
        .st_done (req_wr_s & dhit),
        .addr    (Output_Port_MEM),
        .sc_ok   (sc_ok_s)
    );
`else
    logic unused_ll_s;

    assign sc_fail_s   = 1'b0;
    assign sc_wdat_s   = 32'd1;
    assign unused_ll_s = ll_MEM;
`endif

    assign dmemREN   = req_rd_s;
    assign dmemWEN   = req_wr_s;
    assign dmemaddr  = Output_Port_MEM;
    assign dmemstore = busB_MEM;
    assign mem_stall = memop_eff_s & ~dhit;

    // Handshake FSM: request decode and next state; the request is held in WAIT because upstream is frozen.
    always_comb begin
        state_nxt_s = state_r;
        req_rd_s    = 1'b0;
        req_wr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                req_rd_s = memop_eff_s & ~memWr_MEM;
                req_wr_s = memop_eff_s & memWr_MEM;
                if (memop_eff_s && !dhit) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                req_rd_s = memop_eff_s & ~memWr_MEM;
                req_wr_s = memop_eff_s & memWr_MEM;
                if (!memop_eff_s || dhit) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Redirect decode: branch condition and target selection.
    always_comb begin
        taken_s  = 1'b0;
        target_s = 32'd0;
        case (pcsrc_t'(PC_Src_MEM))
            PC_BR: begin
                taken_s  = zero_MEM ^ bne_MEM;
                target_s = branch_addr_MEM;
            end
            PC_JMP: begin
                taken_s  = 1'b1;
                target_s = jump_addr_MEM;
            end
            PC_JR: begin
                taken_s  = 1'b1;
                target_s = busA_MEM;
            end
            default: begin
                taken_s  = 1'b0;
                target_s = 32'd0;
            end
        endcase
    end

    assign pc_redirect = valid_MEM & ~mem_stall & taken_s;
    assign pc_target   = pc_redirect ? target_s : 32'd0;

    // Writeback data select; SC returns its success flag instead of the selected source.
    always_comb begin
        wdat_nxt_s = Output_Port_MEM;
        if (sc_MEM && memWr_MEM) begin
            wdat_nxt_s = sc_wdat_s;
        end else begin
            case (wsel_t'(Wsel_MEM))
                WB_ALU:  wdat_nxt_s = Output_Port_MEM;
                WB_MEM:  wdat_nxt_s = dmemload;
                WB_LINK: wdat_nxt_s = npc_MEM;
                default: wdat_nxt_s = Output_Port_MEM;
            endcase
        end
    end

    // MEM/WB pipeline register: bubble on stall or flush, otherwise capture the MEM slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_WB <= 1'b0;
            RegWr_WB <= 1'b0;
            wreg_WB  <= 5'd0;
            wdat_WB  <= 32'd0;
        end else if (wb_flush || mem_stall) begin
            valid_WB <= 1'b0;
            RegWr_WB <= 1'b0;
            wreg_WB  <= 5'd0;
            wdat_WB  <= 32'd0;
        end else begin
            valid_WB <= valid_MEM;
            RegWr_WB <= RegWr_MEM & valid_MEM;
            wreg_WB  <= wreg_MEM;
            wdat_WB  <= wdat_nxt_s;
        end
    end

endmodule
